// File: rtl/tdes_pass_scheduler_if.sv
// rtl/tdes_pass_scheduler_if.sv - request/response and DES-core signals of the Triple-DES pass scheduler
//
// Purpose: bundles the host-side request/result signals and the single-DES
// core handshake into one interface.
// Modports:
//   slave  - the scheduler: consumes the request and core result, drives the
//            core command, busy, result and error.
//   master - the environment (bus controller plus DES core) on the other side.
interface tdes_pass_scheduler_if;
    logic        enable;
    logic        encryptionType;
    logic [63:0] data;
    logic [63:0] key1;
    logic [63:0] key2;
    logic [63:0] key3;
    logic        desStart;
    logic [63:0] desIn;
    logic [63:0] desKey;
    logic        desDecrypt;
    logic        desDone;
    logic [63:0] desOut;
    logic        busy;
    logic        outputEnable;
    logic [63:0] outputData;
    logic        error;

    modport slave (
        input  enable, encryptionType, data, key1, key2, key3, desDone, desOut,
        output desStart, desIn, desKey, desDecrypt, busy, outputEnable, outputData, error
    );

    modport master (
        output enable, encryptionType, data, key1, key2, key3, desDone, desOut,
        input  desStart, desIn, desKey, desDecrypt, busy, outputEnable, outputData, error
    );
endinterface

// File: rtl/tdes_pass_scheduler.sv
// rtl/tdes_pass_scheduler.sv - runs one Triple-DES operation as three passes through a shared DES core
//
// Purpose: latches a request, issues three single-DES passes (EDE for
// encrypt, DED for decrypt) with the proper key and direction, chains each
// pass result into the next, and aborts if the core does not answer within
// TIMEOUT_CYCLES wait cycles.
// Ports:
//   HCLK   - clock, rising edge
//   HRESET - synchronous active-high reset
//   bus    - tdes_pass_scheduler_if.slave: request (enable, encryptionType,
//            data, key1..key3), core command (desStart, desIn, desKey,
//            desDecrypt), core result (desDone, desOut), status and result
//            (busy, outputEnable, outputData, error). All outputs registered.
module tdes_pass_scheduler #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    tdes_pass_scheduler_if.slave   bus
);
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  pass_q, pass_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        enc_q, enc_d;
    logic [63:0] k1_q, k1_d;
    logic [63:0] k2_q, k2_d;
    logic [63:0] k3_q, k3_d;
    logic        des_start_q, des_start_d;
    logic [63:0] des_in_q, des_in_d;
    logic [63:0] des_key_q, des_key_d;
    logic        des_decrypt_q, des_decrypt_d;
    logic        busy_q, busy_d;
    logic        out_en_q, out_en_d;
    logic [63:0] out_data_q, out_data_d;
    logic        error_q, error_d;

    // Encrypt walks key1,key2,key3; decrypt walks them in reverse.
    function automatic logic [63:0] pick_key(input logic enc, input logic [1:0] p,
                                             input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] c);
        case (p)
            2'd0:    pick_key = enc ? a : c;
            2'd1:    pick_key = b;
            default: pick_key = enc ? c : a;
        endcase
    endfunction

    // EDE / DED: the middle pass runs opposite to the outer two.
    function automatic logic pick_dec(input logic enc, input logic [1:0] p);
        pick_dec = (p == 2'd1) ? enc : ~enc;
    endfunction

    // State register
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.enable) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion is tested first so a done coinciding with the
                // timeout limit still finishes the operation.
                if (bus.desDone) begin
                    state_d = (pass_q == 2'd2) ? ST_IDLE : ST_ISSUE;
                end else if (tmo_q == TMO_LIMIT) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        pass_d        = pass_q;
        tmo_d         = tmo_q;
        enc_d         = enc_q;
        k1_d          = k1_q;
        k2_d          = k2_q;
        k3_d          = k3_q;
        des_start_d   = 1'b0;
        des_in_d      = des_in_q;
        des_key_d     = des_key_q;
        des_decrypt_d = des_decrypt_q;
        busy_d        = busy_q;
        out_en_d      = 1'b0;
        out_data_d    = out_data_q;
        error_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    enc_d         = bus.encryptionType;
                    k1_d          = bus.key1;
                    k2_d          = bus.key2;
                    k3_d          = bus.key3;
                    pass_d        = 2'd0;
                    busy_d        = 1'b1;
                    des_in_d      = bus.data;
                    des_key_d     = pick_key(bus.encryptionType, 2'd0, bus.key1, bus.key2, bus.key3);
                    des_decrypt_d = pick_dec(bus.encryptionType, 2'd0);
                    des_start_d   = 1'b1;
                end
            end
            ST_ISSUE: begin
                tmo_d = 8'd0;
            end
            ST_WAIT: begin
                if (bus.desDone) begin
                    if (pass_q != 2'd2) begin
                        des_in_d      = bus.desOut;
                        pass_d        = pass_q + 2'd1;
                        des_key_d     = pick_key(enc_q, pass_q + 2'd1, k1_q, k2_q, k3_q);
                        des_decrypt_d = pick_dec(enc_q, pass_q + 2'd1);
                        des_start_d   = 1'b1;
                    end else begin
                        out_data_d = bus.desOut;
                        out_en_d   = 1'b1;
                        busy_d     = 1'b0;
                    end
                end else if (tmo_q == TMO_LIMIT) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pass_q        <= 2'd0;
            tmo_q         <= 8'd0;
            enc_q         <= 1'b0;
            k1_q          <= 64'd0;
            k2_q          <= 64'd0;
            k3_q          <= 64'd0;
            des_start_q   <= 1'b0;
            des_in_q      <= 64'd0;
            des_key_q     <= 64'd0;
            des_decrypt_q <= 1'b0;
            busy_q        <= 1'b0;
            out_en_q      <= 1'b0;
            out_data_q    <= 64'd0;
            error_q       <= 1'b0;
        end else begin
            pass_q        <= pass_d;
            tmo_q         <= tmo_d;
            enc_q         <= enc_d;
            k1_q          <= k1_d;
            k2_q          <= k2_d;
            k3_q          <= k3_d;
            des_start_q   <= des_start_d;
            des_in_q      <= des_in_d;
            des_key_q     <= des_key_d;
            des_decrypt_q <= des_decrypt_d;
            busy_q        <= busy_d;
            out_en_q      <= out_en_d;
            out_data_q    <= out_data_d;
            error_q       <= error_d;
        end
    end

    assign bus.desStart     = des_start_q;
    assign bus.desIn        = des_in_q;
    assign bus.desKey       = des_key_q;
    assign bus.desDecrypt   = des_decrypt_q;
    assign bus.busy         = busy_q;
    assign bus.outputEnable = out_en_q;
    assign bus.outputData   = out_data_q;
    assign bus.error        = error_q;
endmodule

// File: tb/tb_tdes_pass_scheduler.sv
// tb/tb_tdes_pass_scheduler.sv - scoreboard bench for tdes_pass_scheduler with an XOR stub core
module tb_tdes_pass_scheduler;
    localparam int L = 16;
    localparam logic [63:0] K1 = 64'h1111111111111111;
    localparam logic [63:0] K2 = 64'h2222222222222222;
    localparam logic [63:0] K3 = 64'h3333333333333333;

    typedef struct {
        logic [63:0] key;
        logic        dec;
        logic [63:0] din;
    } pass_t;

    typedef struct {
        bit          is_err;
        logic [63:0] data;
        int          lat;
    } res_t;

    logic HCLK = 1'b0;
    logic HRESET = 1'b1;
    tdes_pass_scheduler_if bus();

    tdes_pass_scheduler #(.TIMEOUT_CYCLES(64)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus.slave)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    // Stub core: XOR model, done sampled L edges after desStart is sampled.
    bit   stub_en = 1'b1;
    int   stub_cnt = 0;
    logic stub_done = 1'b0;
    logic inj_done = 1'b0;
    always @(posedge HCLK) begin
        stub_done <= 1'b0;
        if (stub_en && bus.desStart) begin
            stub_cnt <= L - 1;
        end else if (stub_cnt > 0) begin
            if (stub_cnt == 1) stub_done <= 1'b1;
            stub_cnt <= stub_cnt - 1;
        end
    end
    assign bus.desDone = stub_done | inj_done;
    assign bus.desOut  = bus.desIn ^ bus.desKey ^ {64{bus.desDecrypt}};

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    pass_t exp_pass[$];
    res_t  exp_res[$];

    function automatic void push_pass(input logic [63:0] key, input logic dec, input logic [63:0] din);
        pass_t p;
        p.key = key; p.dec = dec; p.din = din;
        exp_pass.push_back(p);
    endfunction

    function automatic void push_res(input bit is_err, input logic [63:0] d, input int lat);
        res_t r;
        r.is_err = is_err; r.data = d; r.lat = lat;
        exp_res.push_back(r);
    endfunction

    // Monitor
    int  ds_cnt = 0, ev_cnt = 0, acc_cnt = 0;
    int  last_acc = 0, last_oe = 0;
    logic busy_prev = 1'b0;
    always @(negedge HCLK) begin
        if (bus.busy && !busy_prev) begin
            acc_cnt++;
            last_acc = cyc;
        end
        if (bus.desStart) begin
            ds_cnt++;
            if (exp_pass.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_desStart actual key=%h dec=%0b required none", bus.desKey, bus.desDecrypt);
            end else begin
                pass_t p;
                p = exp_pass.pop_front();
                check("pass_key", bus.desKey, p.key);
                check("pass_dec", 64'(bus.desDecrypt), 64'(p.dec));
                check("pass_din", bus.desIn, p.din);
            end
        end
        if (bus.outputEnable || bus.error) begin
            ev_cnt++;
            if (exp_res.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_result actual oe=%0b err=%0b data=%h required none",
                         bus.outputEnable, bus.error, bus.outputData);
            end else begin
                res_t r;
                r = exp_res.pop_front();
                check("res_error", 64'(bus.error), 64'(r.is_err));
                check("res_oe", 64'(bus.outputEnable), 64'(!r.is_err));
                check("res_data", bus.outputData, r.data);
                check("res_latency", 64'(cyc - last_acc), 64'(r.lat));
                check("res_busy", 64'(bus.busy), 64'd0);
            end
            if (bus.outputEnable) last_oe = cyc;
        end
        busy_prev = bus.busy;
    end

    task automatic wait_ctr(input string name, input int which, input int target, input int budget);
        int n = 0;
        int v;
        v = (which == 0) ? ev_cnt : (which == 1) ? ds_cnt : acc_cnt;
        while (v < target && n < budget) begin
            @(negedge HCLK);
            n++;
            v = (which == 0) ? ev_cnt : (which == 1) ? ds_cnt : acc_cnt;
        end
        if (v < target) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=%0d required=%0d", name, v, target);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_desStart"}, 64'(bus.desStart), 64'd0);
        check({tag, "_desIn"}, bus.desIn, 64'd0);
        check({tag, "_desKey"}, bus.desKey, 64'd0);
        check({tag, "_desDecrypt"}, 64'(bus.desDecrypt), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_outputEnable"}, 64'(bus.outputEnable), 64'd0);
        check({tag, "_outputData"}, bus.outputData, 64'd0);
        check({tag, "_error"}, 64'(bus.error), 64'd0);
    endtask

    task automatic start_op(input logic enc, input logic [63:0] d);
        @(negedge HCLK);
        bus.encryptionType = enc;
        bus.data = d;
        bus.enable = 1'b1;
        @(negedge HCLK);
        bus.enable = 1'b0;
    endtask

    task automatic push_enc_passes();
        push_pass(K1, 1'b0, 64'h0000000000000001);
        push_pass(K2, 1'b1, 64'h1111111111111110);
        push_pass(K3, 1'b0, 64'hCCCCCCCCCCCCCCCD);
    endtask

    task automatic push_dec_passes();
        push_pass(K3, 1'b1, 64'h0000000000000001);
        push_pass(K2, 1'b0, 64'hCCCCCCCCCCCCCCCD);
        push_pass(K1, 1'b1, 64'hEEEEEEEEEEEEEEEF);
    endtask

    initial begin
        int base_ev, base_ds, base_acc, oe1;
        bus.enable = 1'b0;
        bus.encryptionType = 1'b0;
        bus.data = 64'h0000000000000001;
        bus.key1 = K1;
        bus.key2 = K2;
        bus.key3 = K3;
        repeat (3) @(negedge HCLK);
        HRESET = 1'b0;
        check_reset_outputs("reset");

        // Encrypt
        push_enc_passes();
        push_res(1'b0, 64'hFFFFFFFFFFFFFFFE, 51);
        base_ev = ev_cnt;
        start_op(1'b1, 64'h0000000000000001);
        wait_ctr("encrypt", 0, base_ev + 1, 200);

        // Decrypt
        push_dec_passes();
        push_res(1'b0, 64'h0000000000000001, 51);
        base_ev = ev_cnt;
        start_op(1'b0, 64'h0000000000000001);
        wait_ctr("decrypt", 0, base_ev + 1, 200);

        // New request and key2 change during pass 1 must not disturb the operation
        push_enc_passes();
        push_res(1'b0, 64'hFFFFFFFFFFFFFFFE, 51);
        base_ev = ev_cnt;
        base_ds = ds_cnt;
        start_op(1'b1, 64'h0000000000000001);
        wait_ctr("busy_pass1", 1, base_ds + 2, 100);
        repeat (3) @(negedge HCLK);
        bus.data = 64'hDEADBEEFDEADBEEF;
        bus.key2 = 64'hAAAAAAAAAAAAAAAA;
        bus.encryptionType = 1'b0;
        bus.enable = 1'b1;
        @(negedge HCLK);
        bus.enable = 1'b0;
        wait_ctr("busy_ignore", 0, base_ev + 1, 200);
        repeat (5) @(negedge HCLK);
        check("busy_ignore_no_restart", 64'(bus.busy), 64'd0);
        bus.key2 = K2;

        // Timeout: core never answers
        stub_en = 1'b0;
        push_pass(K1, 1'b0, 64'h0000000000000001);
        push_res(1'b1, 64'hFFFFFFFFFFFFFFFE, 66);
        base_ev = ev_cnt;
        start_op(1'b1, 64'h0000000000000001);
        wait_ctr("timeout", 0, base_ev + 1, 200);

        // Late done after the abort
        base_ds = ds_cnt;
        @(negedge HCLK);
        inj_done = 1'b1;
        @(negedge HCLK);
        inj_done = 1'b0;
        repeat (5) @(negedge HCLK);
        check("late_done_events", 64'(ev_cnt), 64'(base_ev + 1));
        check("late_done_desStart", 64'(ds_cnt), 64'(base_ds));
        check("late_done_busy", 64'(bus.busy), 64'd0);
        check("late_done_data", bus.outputData, 64'hFFFFFFFFFFFFFFFE);
        stub_en = 1'b1;

        // Reset during pass 2, then a stale done from the stub
        push_dec_passes();
        base_ev = ev_cnt;
        base_ds = ds_cnt;
        start_op(1'b0, 64'h0000000000000001);
        wait_ctr("reset_pass2", 1, base_ds + 3, 100);
        repeat (3) @(negedge HCLK);
        HRESET = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0;
        check_reset_outputs("midreset");
        repeat (30) @(negedge HCLK);
        check("stale_done_events", 64'(ev_cnt), 64'(base_ev));
        check("stale_done_desStart", 64'(ds_cnt), 64'(base_ds + 3));
        check("stale_done_data", bus.outputData, 64'd0);

        // Back-to-back with enable held high
        push_enc_passes();
        push_res(1'b0, 64'hFFFFFFFFFFFFFFFE, 51);
        push_enc_passes();
        push_res(1'b0, 64'hFFFFFFFFFFFFFFFE, 51);
        base_ev = ev_cnt;
        base_acc = acc_cnt;
        @(negedge HCLK);
        bus.encryptionType = 1'b1;
        bus.data = 64'h0000000000000001;
        bus.enable = 1'b1;
        wait_ctr("b2b_first", 0, base_ev + 1, 200);
        oe1 = last_oe;
        wait_ctr("b2b_accept", 2, base_acc + 2, 20);
        bus.enable = 1'b0;
        check("b2b_gap", 64'(last_acc - oe1), 64'd1);
        wait_ctr("b2b_second", 0, base_ev + 2, 200);

        repeat (5) @(negedge HCLK);
        check("pass_queue_empty", 64'(exp_pass.size()), 64'd0);
        check("result_queue_empty", 64'(exp_res.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
